// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch stage.
// Holds the PC, addresses the instruction ROM and captures its combinational
// output into the IF/ID register. Handles stall, branch/jump redirect and
// EBREAK halt.
// Optional build macro FETCH_PERF_CNT_EN adds FETCH_CNT / BUBBLE_CNT outputs.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | first cycle after reset; ROM settles, IF/ID gets a bubble
// RUN   | normal fetch: REDIRECT > STALL > advance
// HALT  | EBREAK fetched; PC frozen, bubbles only, left only by RST
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] TARGET,
  input  logic [31:0] INSTRUCTION_IN,
  output logic [31:0] INS_ADDRESS,
  output logic [31:0] PC_ID,
  output logic [31:0] PC4_ID,
  output logic [31:0] INSTR_ID,
  output logic        VALID_ID,
  output logic        HALTED
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_CNT,
  output logic [31:0] BUBBLE_CNT
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_id_q, pc4_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] pc_plus4;
  logic        do_advance;
  logic        do_bubble;

  // The redirect target is forced word aligned, so its two low bits are dropped.
  logic        unused_target_lsb;
  assign unused_target_lsb = ^TARGET[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state logic for the FSM, the PC and the IF/ID register.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
    do_advance = 1'b0;
    do_bubble  = 1'b0;

    case (state_q)
      ST_BOOT: begin
        do_bubble = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (REDIRECT) begin
          pc_d      = {TARGET[31:2], 2'b00};
          do_bubble = 1'b1;
        end else if (!STALL) begin
          do_advance = 1'b1;
          // An EBREAK parks the PC on its own address.
          if (INSTRUCTION_IN == EBREAK_INSTR) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_HALT: begin
        do_bubble = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (do_advance) begin
      pc_id_d    = pc_q;
      pc4_id_d   = pc_plus4;
      instr_id_d = INSTRUCTION_IN;
      valid_id_d = 1'b1;
    end else if (do_bubble) begin
      // PC_ID / PC4_ID intentionally hold through a bubble.
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc_id_q    <= 32'd0;
      pc4_id_q   <= 32'd0;
      instr_id_q <= NOP_INSTR;
      valid_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      pc4_id_q   <= pc4_id_d;
      instr_id_q <= instr_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  assign INS_ADDRESS = pc_q;
  assign PC_ID       = pc_id_q;
  assign PC4_ID      = pc4_id_q;
  assign INSTR_ID    = instr_id_q;
  assign VALID_ID    = valid_id_q;
  assign HALTED      = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counters step on advance/bubble edges; a stalled RUN edge is neither.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, do_advance};
    bubble_cnt_d = bubble_cnt_q + {31'd0, do_bubble};
  end

  // Counter registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign FETCH_CNT  = fetch_cnt_q;
  assign BUBBLE_CNT = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural model compared every cycle plus
// directed literal expectations; a second instance covers PC wrap-around.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk;
  logic        RST, STALL, REDIRECT;
  logic [31:0] TARGET, INSTRUCTION_IN;
  logic [31:0] INS_ADDRESS, PC_ID, PC4_ID, INSTR_ID;
  logic        VALID_ID, HALTED;

  logic        rst2;
  logic [31:0] instr2, ia2, pc_id2, pc4_id2, instr_id2;
  logic        valid2, halted2;

  logic [31:0] rom [0:63];

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FETCH_CNT, BUBBLE_CNT, fcnt2, bcnt2;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .RST(RST), .STALL(STALL), .REDIRECT(REDIRECT), .TARGET(TARGET),
    .INSTRUCTION_IN(INSTRUCTION_IN), .INS_ADDRESS(INS_ADDRESS), .PC_ID(PC_ID),
    .PC4_ID(PC4_ID), .INSTR_ID(INSTR_ID), .VALID_ID(VALID_ID), .HALTED(HALTED)
`ifdef FETCH_PERF_CNT_EN
    , .FETCH_CNT(FETCH_CNT), .BUBBLE_CNT(BUBBLE_CNT)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .CLK(clk), .RST(rst2), .STALL(1'b0), .REDIRECT(1'b0), .TARGET(32'd0),
    .INSTRUCTION_IN(instr2), .INS_ADDRESS(ia2), .PC_ID(pc_id2),
    .PC4_ID(pc4_id2), .INSTR_ID(instr_id2), .VALID_ID(valid2), .HALTED(halted2)
`ifdef FETCH_PERF_CNT_EN
    , .FETCH_CNT(fcnt2), .BUBBLE_CNT(bcnt2)
`endif
  );

  assign INSTRUCTION_IN = rom[INS_ADDRESS[7:2]];
  assign instr2         = rom[ia2[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    return rom[a[7:2]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what IF/ID and the PC must hold after each edge.
  logic [31:0] m_pc, m_pc_id, m_pc4, m_instr;
  logic        m_valid, m_halted, m_boot;
  logic [31:0] m_fcnt, m_bcnt;

  always @(posedge clk) begin
    if (RST) begin
      m_pc <= 32'd0; m_pc_id <= 32'd0; m_pc4 <= 32'd0; m_instr <= NOP;
      m_valid <= 1'b0; m_halted <= 1'b0; m_boot <= 1'b1;
      m_fcnt <= 32'd0; m_bcnt <= 32'd0;
    end else if (m_boot || m_halted) begin
      m_boot <= 1'b0; m_instr <= NOP; m_valid <= 1'b0; m_bcnt <= m_bcnt + 32'd1;
    end else if (REDIRECT) begin
      m_pc <= TARGET & ~32'd3; m_instr <= NOP; m_valid <= 1'b0;
      m_bcnt <= m_bcnt + 32'd1;
    end else if (!STALL) begin
      m_pc_id <= m_pc; m_pc4 <= m_pc + 32'd4; m_instr <= rom_at(m_pc);
      m_valid <= 1'b1; m_fcnt <= m_fcnt + 32'd1;
      if (rom_at(m_pc) == EBREAK) m_halted <= 1'b1;
      else m_pc <= m_pc + 32'd4;
    end
  end

  // Compare process: outputs checked against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ins_address", INS_ADDRESS, m_pc);
      chk("m_pc_id", PC_ID, m_pc_id);
      chk("m_pc4_id", PC4_ID, m_pc4);
      chk("m_instr_id", INSTR_ID, m_instr);
      chk("m_valid_id", {31'd0, VALID_ID}, {31'd0, m_valid});
      chk("m_halted", {31'd0, HALTED}, {31'd0, m_halted});
`ifdef FETCH_PERF_CNT_EN
      chk("m_fetch_cnt", FETCH_CNT, m_fcnt);
      chk("m_bubble_cnt", BUBBLE_CNT, m_bcnt);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {12'(i + 1), 20'h00093};
    rom[12] = EBREAK;
    RST = 1'b1; STALL = 1'b0; REDIRECT = 1'b0; TARGET = 32'd0; rst2 = 1'b1;

    // 1. reset and boot
    step(1);
    chk_en = 1'b1;
    step(1);
    chk("rst_ins_address", INS_ADDRESS, 32'h0);
    chk("rst_valid", {31'd0, VALID_ID}, 32'd0);
    chk("rst_instr", INSTR_ID, NOP);
    chk("rst_halted", {31'd0, HALTED}, 32'd0);
    chk("rst_pc_id", PC_ID, 32'h0);
    RST = 1'b0;
    step(1);
    chk("boot_ins_address", INS_ADDRESS, 32'h0);
    chk("boot_valid", {31'd0, VALID_ID}, 32'd0);
    step(1);
    chk("first_instr", INSTR_ID, 32'h0010_0093);
    chk("first_pc_id", PC_ID, 32'h0);
    chk("first_pc4_id", PC4_ID, 32'h4);
    chk("first_ins_address", INS_ADDRESS, 32'h4);
    step(1);
    chk("seq_ins_address", INS_ADDRESS, 32'h8);
    step(2);
    chk("pre_stall_pc", INS_ADDRESS, 32'h10);

    // 2. stall for 3 cycles
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_ins_address", INS_ADDRESS, 32'h10);
      chk("stall_instr", INSTR_ID, 32'h0040_0093);
      chk("stall_pc_id", PC_ID, 32'hC);
    end
    STALL = 1'b0;
    step(1);
    chk("post_stall_pc", INS_ADDRESS, 32'h14);
    chk("post_stall_instr", INSTR_ID, 32'h0050_0093);
    step(3);

    // 3. redirect overriding a simultaneous stall
    REDIRECT = 1'b1; STALL = 1'b1; TARGET = 32'h0000_0043;
    step(1);
    chk("redir_ins_address", INS_ADDRESS, 32'h40);
    chk("redir_instr", INSTR_ID, NOP);
    chk("redir_valid", {31'd0, VALID_ID}, 32'd0);
    chk("redir_pc_id_hold", PC_ID, 32'h1C);
    REDIRECT = 1'b0; STALL = 1'b0;
    step(1);
    chk("target_instr", INSTR_ID, 32'h0110_0093);
    chk("target_pc_id", PC_ID, 32'h40);

    // 4. halt on EBREAK at 0x30
    REDIRECT = 1'b1; TARGET = 32'h0000_002E;
    step(1);
    chk("redir2_ins_address", INS_ADDRESS, 32'h2C);
    REDIRECT = 1'b0;
    step(2);
    chk("halt_instr", INSTR_ID, EBREAK);
    chk("halt_valid", {31'd0, VALID_ID}, 32'd1);
    chk("halt_flag", {31'd0, HALTED}, 32'd1);
    chk("halt_ins_address", INS_ADDRESS, 32'h30);
    step(1);
    chk("halted_valid", {31'd0, VALID_ID}, 32'd0);
    chk("halted_ins_address", INS_ADDRESS, 32'h30);
    REDIRECT = 1'b1; STALL = 1'b1; TARGET = 32'h80;
    step(1);
    chk("halt_ignores_redir", INS_ADDRESS, 32'h30);
    chk("halt_sticky", {31'd0, HALTED}, 32'd1);
    REDIRECT = 1'b0; STALL = 1'b0; RST = 1'b1;
    step(1);
    chk("halt_rst_address", INS_ADDRESS, 32'h0);
    chk("halt_rst_flag", {31'd0, HALTED}, 32'd0);
    RST = 1'b0;
    step(3);
    chk("restart_address", INS_ADDRESS, 32'h8);
    STALL = 1'b1;
    step(1);
    RST = 1'b1;
    step(1);
    chk("stall_rst_address", INS_ADDRESS, 32'h0);
    RST = 1'b0; STALL = 1'b0;
    step(4);

    // 5. wrap-around instance
    chk("wrap_rst_address", ia2, 32'hFFFF_FFF8);
    rst2 = 1'b0;
    step(1);
    chk("wrap_boot_address", ia2, 32'hFFFF_FFF8);
    step(1);
    chk("wrap_addr1", ia2, 32'hFFFF_FFFC);
    chk("wrap_pc_id1", pc_id2, 32'hFFFF_FFF8);
    step(1);
    chk("wrap_addr2", ia2, 32'h0000_0000);
    chk("wrap_pc_id2", pc_id2, 32'hFFFF_FFFC);
    chk("wrap_pc4_id", pc4_id2, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
